// File: rtl/cmd_sequencer.sv
// -----------------------------------------------------------------------------
// cmd_sequencer
//
// Plays a queue of host commands (8-bit opcode + 16-bit data) through the
// RemoteComm host-side UART master, one at a time. Commands are buffered in a
// 4-deep FIFO. Each command is sent with a send_cmd pulse. The sequencer then
// waits for cmd_sent and then for a response byte. The byte is knocked down
// with clr_resp_rdy and compared against ACK. Failed attempts (NAK or
// timeout) are re-sent up to MAX_RETRY times. After that the command is
// discarded and err is pulsed with a reason code.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   push            enqueue {cmd_in, data_in} this cycle
//   cmd_in, data_in command to enqueue
//   full, empty     FIFO occupancy flags (4 / 0 entries)
//   ovfl            1-clk pulse: push dropped because FIFO was full
//   cmd, data       command presented to RemoteComm (held while idle)
//   send_cmd        1-clk pulse to RemoteComm to start a packet
//   cmd_sent        RemoteComm finished transmitting the packet
//   resp_rdy, resp  RemoteComm holds a response byte
//   clr_resp_rdy    1-clk pulse to knock down resp_rdy
//   busy            sequencer is not idle
//   done            1-clk pulse: head command acknowledged
//   err, err_code   1-clk pulse: head command discarded;
//                   err_code 01 = NAK, 10 = timeout
// -----------------------------------------------------------------------------
module cmd_sequencer #(
  parameter logic [19:0] TIMEOUT     = 20'd100000,
  parameter logic [23:0] CAL_TIMEOUT = 24'd4000000,
  parameter int          MAX_RETRY   = 2,
  parameter logic [7:0]  ACK         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  cmd_in,
  input  logic [15:0] data_in,
  output logic        full,
  output logic        empty,
  output logic        ovfl,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [7:0] CAL_OPCODE = 8'h06;
  localparam logic [3:0] MAX_R      = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SENT,
    WAIT_RESP,
    CLR,
    DECIDE
  } state_t;

  // Saturating increment for the 24-bit attempt timer.
  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFF_FFFF) ? v : v + 24'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // FIFO: 4 x 24 bits, pointers carry an extra wrap bit
  // ---------------------------------------------------------------------------
  logic [23:0] fifo_mem [4];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic        do_push;
  logic        pop;
  logic [23:0] head;

  assign full    = (wr_ptr[1:0] == rd_ptr[1:0]) && (wr_ptr[2] != rd_ptr[2]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign head    = fifo_mem[rd_ptr[1:0]];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr[1:0]] <= {cmd_in, data_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      ovfl   <= 1'b0;
    end else begin
      // A push is judged against 'full' before any pop in the same cycle.
      ovfl <= push && full;
      if (do_push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [3:0]  retry_cnt;
  logic [23:0] timer;
  logic        timed_out;
  logic [7:0]  resp_lat;
  logic [23:0] limit;
  logic        at_limit;
  logic        ack_ok;
  logic        retry_left;

  // The limit follows the registered opcode, which is stable for the attempt.
  assign limit      = (cmd == CAL_OPCODE) ? CAL_TIMEOUT : {4'd0, TIMEOUT};
  assign at_limit   = (timer >= limit);
  assign ack_ok     = (resp_lat == ACK) && !timed_out;
  assign retry_left = (retry_cnt < MAX_R);
  assign busy       = (state != IDLE);

  // The head leaves the FIFO on success or when the last retry has failed.
  assign pop = (state == DECIDE) && (ack_ok || !retry_left);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd          <= 8'd0;
      data         <= 16'd0;
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      retry_cnt    <= 4'd0;
      timer        <= 24'd0;
      timed_out    <= 1'b0;
      resp_lat     <= 8'd0;
    end else begin
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;

      case (state)
        IDLE: begin
          // cmd/data are captured on entry to LOAD so they are already
          // stable in the cycle that carries send_cmd.
          if (!empty) begin
            state     <= LOAD;
            cmd       <= head[23:16];
            data      <= head[15:0];
            send_cmd  <= 1'b1;
            timer     <= 24'd0;
            timed_out <= 1'b0;
          end
        end

        LOAD: begin
          state <= WAIT_SENT;
        end

        WAIT_SENT: begin
          timer <= sat_inc(timer);
          if (cmd_sent) begin
            state <= WAIT_RESP;
          end else if (at_limit) begin
            state     <= DECIDE;
            timed_out <= 1'b1;
          end
        end

        WAIT_RESP: begin
          timer <= sat_inc(timer);
          // A response arriving on the limit cycle still counts.
          if (resp_rdy) begin
            state        <= CLR;
            clr_resp_rdy <= 1'b1;
            resp_lat     <= resp;
          end else if (at_limit) begin
            state     <= DECIDE;
            timed_out <= 1'b1;
          end
        end

        CLR: begin
          state <= DECIDE;
        end

        DECIDE: begin
          if (ack_ok) begin
            done      <= 1'b1;
            retry_cnt <= 4'd0;
            state     <= IDLE;
          end else if (retry_left) begin
            // Re-send the same head; it has not been popped.
            retry_cnt <= retry_cnt + 4'd1;
            state     <= LOAD;
            cmd       <= head[23:16];
            data      <= head[15:0];
            send_cmd  <= 1'b1;
            timer     <= 24'd0;
            timed_out <= 1'b0;
          end else begin
            err       <= 1'b1;
            err_code  <= timed_out ? 2'b10 : 2'b01;
            retry_cnt <= 4'd0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cmd_sequencer
//
// Bench for cmd_sequencer. A RemoteComm stand-in answers each send_cmd with
// cmd_sent and then a planned response (a byte, or silence). When a command
// is pushed, the reference model expands its per-attempt response plan into
// the expected packets and the final outcome. A monitor checks every
// send_cmd, done and err against those expectations.
// -----------------------------------------------------------------------------
module tb_cmd_sequencer;

  localparam logic [19:0] TB_TIMEOUT = 20'd1000;
  localparam logic [23:0] TB_CAL     = 24'd20000;
  localparam int          ACK_V      = 'hA5;
  localparam int          SILENT     = -1;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [7:0]  cmd_in;
  logic [15:0] data_in;
  logic        full;
  logic        empty;
  logic        ovfl;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  cmd_sequencer #(
    .TIMEOUT    (TB_TIMEOUT),
    .CAL_TIMEOUT(TB_CAL),
    .MAX_RETRY  (2),
    .ACK        (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .cmd_in      (cmd_in),
    .data_in     (data_in),
    .full        (full),
    .empty       (empty),
    .ovfl        (ovfl),
    .cmd         (cmd),
    .data        (data),
    .send_cmd    (send_cmd),
    .cmd_sent    (cmd_sent),
    .resp_rdy    (resp_rdy),
    .resp        (resp),
    .clr_resp_rdy(clr_resp_rdy),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int r;
    int dly;
  } rsp_t;

  rsp_t        rq[$];        // responses for successive send_cmd pulses
  logic [23:0] exp_send[$];  // expected {cmd,data} per send_cmd
  int          exp_out[$];   // 0 = done, 1 = err NAK, 2 = err timeout
  int          send_cyc[$];
  int          mcount   = 0; // model FIFO occupancy (never under-estimates)
  int          ovfl_exp = 0;
  int          ovfl_seen = 0;
  bit          hold     = 1'b0;
  int          n_cmp    = 0;
  int          n_mis    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rnd_nak();
    int v;
    do v = int'($urandom_range(0, 255)); while (v == ACK_V);
    return v;
  endfunction

  function automatic int rnd_rsp();
    int p;
    p = int'($urandom_range(0, 9));
    if (p < 5) return ACK_V;
    if (p < 8) return rnd_nak();
    return SILENT;
  endfunction

  // Push one command; the model expands its attempt plan up front.
  task automatic push_cmd(input logic [7:0] c, input logic [15:0] d,
                          input int r0, input int r1, input int r2, input int dly);
    int  rs[3];
    bit  drop;
    rs[0] = r0; rs[1] = r1; rs[2] = r2;
    drop = (mcount == 4);
    if (drop) begin
      ovfl_exp++;
    end else begin
      mcount++;
      for (int a = 0; a < 3; a++) begin
        exp_send.push_back({c, d});
        rq.push_back('{rs[a], dly});
        if (rs[a] == ACK_V) begin
          exp_out.push_back(0);
          break;
        end
        if (a == 2) exp_out.push_back((rs[a] == SILENT) ? 2 : 1);
      end
    end
    push    = 1'b1;
    cmd_in  = c;
    data_in = d;
    @(negedge clk);
    push = 1'b0;
    chk("ovfl_on_push", ovfl, drop);
    chk("full_after_push", full, (mcount == 4));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (k < budget && !(exp_send.size() == 0 && exp_out.size() == 0 && !busy)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain_sends_left", exp_send.size(), 0);
    chk("drain_outcomes_left", exp_out.size(), 0);
    chk("busy_when_drained", busy, 0);
    chk("empty_when_drained", empty, 1);
  endtask

  // RemoteComm stand-in.
  initial begin : responder
    rsp_t cur;
    int   k;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp     = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_n && send_cmd) begin
        if (rq.size() == 0) cur = '{SILENT, 1};
        else cur = rq.pop_front();
        k = 0;
        while (hold && k < 900) begin @(negedge clk); k++; end
        repeat ($urandom_range(1, 8)) @(negedge clk);
        cmd_sent = 1'b1;
        @(negedge clk);
        cmd_sent = 1'b0;
        if (cur.r != SILENT) begin
          repeat (cur.dly) @(negedge clk);
          resp     = cur.r[7:0];
          resp_rdy = 1'b1;
          k = 0;
          while (!clr_resp_rdy && k < 100) begin @(negedge clk); k++; end
          resp_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: every packet and every outcome against the model.
  always @(negedge clk) begin : monitor
    logic [23:0] e;
    int          obs;
    if (rst_n) begin
      if (send_cmd) begin
        send_cyc.push_back(cyc);
        if (exp_send.size() == 0) begin
          chk("send_unexpected", exp_send.size(), 1);
        end else begin
          e = exp_send.pop_front();
          chk("send_cmd_data", {8'h0, cmd, data}, {8'h0, e});
        end
      end
      if (done || err) begin
        obs = done ? (err ? 3 : 0) : int'(err_code);
        if (exp_out.size() == 0) chk("outcome_unexpected", exp_out.size(), 1);
        else chk("outcome", obs, exp_out.pop_front());
        if (mcount > 0) mcount--;
      end
      if (ovfl) ovfl_seen++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g;
    int k;
    logic [7:0] rc;
    rst_n   = 1'b0;
    push    = 1'b0;
    cmd_in  = 8'd0;
    data_in = 16'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_send_cmd", send_cmd, 0);
    chk("rst_done_err", {done, err, ovfl, clr_resp_rdy}, 0);
    chk("rst_cmd_data", {cmd, data}, 0);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two acked commands; first send_cmd exactly 2 clks after the push
    push_cmd(8'h06, 16'h0000, ACK_V, ACK_V, ACK_V, 5);
    chk("latency_clk1", send_cmd, 0);
    push_cmd(8'h05, 16'h00FF, ACK_V, ACK_V, ACK_V, 5);
    chk("latency_clk2", send_cmd, 1);
    wait_drain(2000);
    chk("cmd_held_idle", {cmd, data}, {8'h05, 16'h00FF});

    // Five pushes while stalled in WAIT_SENT: 4 accepted, 5th overflows
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'h10 + 8'(i), 16'($urandom), ACK_V, ACK_V, ACK_V, 3);
    end
    hold = 1'b0;
    wait_drain(3000);
    chk("ovfl_count", ovfl_seen, 1);

    // NAK twice then ACK: three identical packets, then done
    send_cyc.delete();
    push_cmd(8'h02, 16'h0010, 'h00, 'h00, ACK_V, 4);
    wait_drain(3000);
    chk("retry_send_count", send_cyc.size(), 3);

    // Silent responder: three sends one timeout apart, then err 10
    send_cyc.delete();
    push_cmd(8'h04, 16'h1234, SILENT, SILENT, SILENT, 1);
    wait_drain(5000);
    chk("timeout_send_count", send_cyc.size(), 3);
    for (int i = 1; i < send_cyc.size(); i++) begin
      g = send_cyc[i] - send_cyc[i-1];
      chk("timeout_gap_in_range", (g >= 1000 && g <= 1016), 1);
    end

    // NAK three times: err 01
    push_cmd(8'h03, 16'hBEEF, rnd_nak(), rnd_nak(), rnd_nak(), 2);
    wait_drain(3000);

    // Calibrate answered long after TIMEOUT but inside CAL_TIMEOUT
    send_cyc.delete();
    push_cmd(8'h06, 16'h0000, ACK_V, ACK_V, ACK_V, 3000);
    wait_drain(10000);
    chk("cal_send_count", send_cyc.size(), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      k = 0;
      while (mcount >= 3 && k < 5000) begin @(negedge clk); k++; end
      rc = 8'($urandom);
      if (rc == 8'h06) rc = 8'h07;
      push_cmd(rc, 16'($urandom), rnd_rsp(), rnd_rsp(), rnd_rsp(), int'($urandom_range(1, 40)));
    end
    wait_drain(40000);

    // Asynchronous reset while waiting for a response with a full FIFO
    push_cmd(8'h21, 16'h0001, SILENT, SILENT, SILENT, 1);
    push_cmd(8'h22, 16'h0002, ACK_V, ACK_V, ACK_V, 1);
    push_cmd(8'h23, 16'h0003, ACK_V, ACK_V, ACK_V, 1);
    push_cmd(8'h24, 16'h0004, ACK_V, ACK_V, ACK_V, 1);
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_full", full, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_full", full, 0);
    chk("async_empty", empty, 1);
    chk("async_pulses", {send_cmd, clr_resp_rdy, done, err, ovfl}, 0);
    chk("async_cmd_data", {cmd, data}, 0);
    chk("async_err_code", err_code, 0);
    rq.delete();
    exp_send.delete();
    exp_out.delete();
    mcount = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery after reset
    push_cmd(8'h09, 16'h0042, ACK_V, ACK_V, ACK_V, 6);
    wait_drain(2000);
    chk("ovfl_total", ovfl_seen, ovfl_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
